// File: rtl/trace_stream_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trace_stream_pkg
// Shared constants, FSM state encoding, trace record layout and the beat
// select helper for the trace record streamer.
// -----------------------------------------------------------------------------
package trace_stream_pkg;

    localparam int unsigned TRACE_REC_W     = 129;
    localparam int unsigned TRACE_VALID_BIT = 128;
    localparam int unsigned TRACE_PAYLOAD_W = 128;
    localparam int unsigned BEATS_PER_REC   = 4;
    localparam int unsigned BEAT_W          = TRACE_PAYLOAD_W / BEATS_PER_REC;
    localparam int unsigned BEAT_IDX_W      = $clog2(BEATS_PER_REC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Raw record as delivered by the trace core: strobe on top, payload below.
    typedef struct packed {
        logic                       valid;
        logic [TRACE_PAYLOAD_W-1:0] payload;
    } trace_rec_t;

    // Beat idx of a record; beat 0 is the least significant word.
    function automatic logic [BEAT_W-1:0] beat_slice(
        input logic [TRACE_PAYLOAD_W-1:0] rec,
        input logic [BEAT_IDX_W-1:0]      idx
    );
        return rec[32'(idx) * BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/trace_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// trace_stream_if
// 32-bit valid/ready beat stream between the trace streamer and its sink.
//   m_data  : current beat
//   m_valid : beat valid
//   m_last  : final beat of a record
//   m_ready : sink ready
// -----------------------------------------------------------------------------
interface trace_stream_if;
    import trace_stream_pkg::*;

    logic [BEAT_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/trace_stream_ctrl_rec_fifo.sv
// -----------------------------------------------------------------------------
// trace_rec_fifo
// Synchronous DEPTH x 128-bit record FIFO with clear.
//   clk, rst  : clock, synchronous active-high reset
//   push      : write wr_data (ignored when full)
//   pop       : advance read pointer (ignored when empty)
//   clear     : discard all entries; wins over push/pop
//   rd_data_c : head entry, combinational read of the storage array
//   full      : level == DEPTH (registered)
//   empty     : level == 0 (registered)
//   level     : number of stored entries, 0..DEPTH (registered)
// -----------------------------------------------------------------------------
module trace_rec_fifo
    import trace_stream_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [TRACE_PAYLOAD_W-1:0] wr_data,
    output logic [TRACE_PAYLOAD_W-1:0] rd_data_c,
    output logic                       full,
    output logic                       empty,
    output logic [LVL_W-1:0]           level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [TRACE_PAYLOAD_W-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit beyond the address.
    logic [LVL_W-1:0] wr_ptr;
    logic [LVL_W-1:0] rd_ptr;
    logic [LVL_W-1:0] wr_ptr_nxt;
    logic [LVL_W-1:0] rd_ptr_nxt;
    logic [LVL_W-1:0] level_nxt;
    logic             do_push;
    logic             do_pop;

    // Next pointer / occupancy computation.
    always_comb begin
        do_push    = push && !full && !clear;
        do_pop     = pop && !empty && !clear;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        level_nxt  = level;
        if (clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            level_nxt  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_nxt = wr_ptr + LVL_W'(1);
            end
            if (do_pop) begin
                rd_ptr_nxt = rd_ptr + LVL_W'(1);
            end
            level_nxt = level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= level_nxt;
            full   <= (level_nxt == LVL_W'(DEPTH));
            empty  <= (level_nxt == '0);
        end
    end

    // Storage array, no reset needed: contents are only read behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trace_stream_ctrl.sv
// -----------------------------------------------------------------------------
// trace_stream_ctrl
// Captures 128-bit trace records into a FIFO and serialises each record into
// four 32-bit beats on a valid/ready stream; counts records lost to overflow.
//   clk, rst     : clock, synchronous active-high reset
//   trace_data_i : [128] record strobe, [127:0] record payload
//   capture_en   : level, records accepted only while high
//   flush        : pulse, drops buffered and in-flight records
//   m_if         : beat stream (m_data, m_valid, m_last out; m_ready in)
//   fifo_level   : records buffered, excluding the one being sent
//   drop_count   : saturating count of records rejected on a full FIFO
//   busy         : FIFO non-empty or a record is being sent
// -----------------------------------------------------------------------------
module trace_stream_ctrl
    import trace_stream_pkg::*;
#(
    parameter  int unsigned DEPTH  = 8,
    parameter  int unsigned DROP_W = 16,
    localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [TRACE_REC_W-1:0] trace_data_i,
    input  logic                   capture_en,
    input  logic                   flush,
    trace_stream_if.master         m_if,
    output logic [LVL_W-1:0]       fifo_level,
    output logic [DROP_W-1:0]      drop_count,
    output logic                   busy
);

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_REC - 1);

    trace_rec_t rec_in;

    logic                       rec_accept;
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_clear;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [TRACE_PAYLOAD_W-1:0] fifo_head;
    logic [LVL_W-1:0]           lvl_nxt;

    state_t                     state;
    state_t                     state_nxt;
    logic [TRACE_PAYLOAD_W-1:0] rec_q;
    logic [TRACE_PAYLOAD_W-1:0] rec_nxt;
    logic [BEAT_IDX_W-1:0]      beat_q;
    logic [BEAT_IDX_W-1:0]      beat_nxt;
    logic [BEAT_W-1:0]          m_data_q;
    logic [BEAT_W-1:0]          m_data_nxt;
    logic                       m_valid_q;
    logic                       m_valid_nxt;
    logic                       m_last_q;
    logic                       m_last_nxt;
    logic [DROP_W-1:0]          drop_q;
    logic [DROP_W-1:0]          drop_nxt;
    logic                       busy_q;
    logic                       busy_nxt;

    assign rec_in = trace_rec_t'(trace_data_i);

    // Full is sampled before any same-cycle pop, so a pop never makes room.
    assign rec_accept = rec_in.valid && capture_en && !flush;
    assign fifo_push  = rec_accept && !fifo_full;

    trace_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .wr_data   (rec_in.payload),
        .rd_data_c (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Next-state, serialiser and drop-counter logic.
    always_comb begin
        state_nxt   = state;
        rec_nxt     = rec_q;
        beat_nxt    = beat_q;
        m_data_nxt  = m_data_q;
        m_valid_nxt = m_valid_q;
        m_last_nxt  = m_last_q;
        drop_nxt    = drop_q;
        fifo_pop    = 1'b0;
        fifo_clear  = 1'b0;

        if (rec_accept && fifo_full && (drop_q != '1)) begin
            drop_nxt = drop_q + DROP_W'(1);
        end

        if (flush) begin
            state_nxt   = FLUSH;
            fifo_clear  = 1'b1;
            beat_nxt    = '0;
            m_valid_nxt = 1'b0;
            m_last_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        rec_nxt     = fifo_head;
                        beat_nxt    = '0;
                        m_data_nxt  = beat_slice(fifo_head, '0);
                        m_valid_nxt = 1'b1;
                        m_last_nxt  = 1'b0;
                        state_nxt   = SEND;
                    end
                end
                SEND: begin
                    if (m_valid_q && m_if.m_ready) begin
                        if (beat_q == LAST_BEAT) begin
                            if (!fifo_empty) begin
                                // Back-to-back record, no idle bubble.
                                fifo_pop    = 1'b1;
                                rec_nxt     = fifo_head;
                                beat_nxt    = '0;
                                m_data_nxt  = beat_slice(fifo_head, '0);
                                m_valid_nxt = 1'b1;
                                m_last_nxt  = 1'b0;
                            end else begin
                                m_valid_nxt = 1'b0;
                                m_last_nxt  = 1'b0;
                                state_nxt   = IDLE;
                            end
                        end else begin
                            beat_nxt   = beat_q + BEAT_IDX_W'(1);
                            m_data_nxt = beat_slice(rec_q, beat_q + BEAT_IDX_W'(1));
                            m_last_nxt = ((beat_q + BEAT_IDX_W'(1)) == LAST_BEAT);
                        end
                    end
                end
                FLUSH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        // Mirror of the FIFO occupancy update so busy can be registered.
        if (fifo_clear) begin
            lvl_nxt = '0;
        end else begin
            lvl_nxt = fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop);
        end
        busy_nxt = (lvl_nxt != '0) || (state_nxt == SEND);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rec_q     <= '0;
            beat_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            drop_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            rec_q     <= rec_nxt;
            beat_q    <= beat_nxt;
            m_data_q  <= m_data_nxt;
            m_valid_q <= m_valid_nxt;
            m_last_q  <= m_last_nxt;
            drop_q    <= drop_nxt;
            busy_q    <= busy_nxt;
        end
    end

    assign m_if.m_data  = m_data_q;
    assign m_if.m_valid = m_valid_q;
    assign m_if.m_last  = m_last_q;
    assign drop_count   = drop_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_trace_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trace_stream_ctrl
// Directed self-checking bench for trace_stream_ctrl (DEPTH=8, DROP_W=16).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trace_stream_ctrl;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 16;
    localparam int unsigned LVL_W  = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [128:0]       trace_data;
    logic               capture_en;
    logic               flush;
    logic [LVL_W-1:0]   fifo_level;
    logic [DROP_W-1:0]  drop_count;
    logic               busy;

    trace_stream_if sif ();

    trace_stream_ctrl #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trace_data_i (trace_data),
        .capture_en   (capture_en),
        .flush        (flush),
        .m_if         (sif),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] cap_data [64];
    logic        cap_last [64];
    int          cap_n;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        trace_data  = '0;
        capture_en  = 1'b1;
        flush       = 1'b0;
        sif.m_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_rec(input logic [127:0] p);
        trace_data = {1'b1, p};
        tick();
        trace_data = '0;
    endtask

    // Records beats on each handshake until n are seen or the budget expires.
    task automatic collect(input int n, input int budget);
        cap_n = 0;
        for (int c = 0; c < budget && cap_n < n; c++) begin
            if (sif.m_valid && sif.m_ready) begin
                cap_data[cap_n] = sif.m_data;
                cap_last[cap_n] = sif.m_last;
                cap_n++;
            end
            tick();
        end
    endtask

    // Word k of record id is 0xA000_0000 | id<<8 | k.
    function automatic logic [127:0] mk_rec(input int unsigned id);
        logic [127:0] r;
        for (int j = 0; j < 4; j++) begin
            r[32*j +: 32] = 32'hA000_0000 | (id << 8) | 32'(j);
        end
        return r;
    endfunction

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_single [4];
        logic [31:0] prev_data;
        logic        prev_stall;

        exp_single[0] = 32'h1111_1111;
        exp_single[1] = 32'h2222_2222;
        exp_single[2] = 32'h3333_3333;
        exp_single[3] = 32'h4444_4444;

        // Reset values
        do_reset();
        check("rst_valid", sif.m_valid, 0);
        check("rst_last", sif.m_last, 0);
        check("rst_data", sif.m_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_drop", drop_count, 0);
        check("rst_busy", busy, 0);

        // Single record, sink always ready
        sif.m_ready = 1'b1;
        send_rec(128'h44444444_33333333_22222222_11111111);
        check("single_pre_valid", sif.m_valid, 0);
        check("single_pre_level", fifo_level, 1);
        check("single_pre_busy", busy, 1);
        tick();
        check("single_valid", sif.m_valid, 1);
        check("single_level", fifo_level, 0);
        collect(4, 12);
        check("single_beats", cap_n, 4);
        for (int k = 0; k < 4; k++) begin
            check("single_data", cap_data[k], exp_single[k]);
            check("single_last", cap_last[k], (k == 3));
        end
        check("single_end_valid", sif.m_valid, 0);
        check("single_end_busy", busy, 0);

        // Back-pressure: ready high on every third cycle
        sif.m_ready = 1'b0;
        send_rec(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
        tick();
        cap_n      = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 20; i++) begin
            sif.m_ready = (i % 3 == 0);
            if (prev_stall) begin
                check("bp_hold", sif.m_data, prev_data);
            end
            if (sif.m_valid && sif.m_ready) begin
                cap_data[cap_n] = sif.m_data;
                cap_last[cap_n] = sif.m_last;
                cap_n++;
            end
            prev_stall = sif.m_valid && !sif.m_ready;
            prev_data  = sif.m_data;
            tick();
        end
        check("bp_beats", cap_n, 4);
        check("bp_b0", cap_data[0], 32'hAAAA_AAAA);
        check("bp_b1", cap_data[1], 32'hBBBB_BBBB);
        check("bp_b2", cap_data[2], 32'hCCCC_CCCC);
        check("bp_b3", cap_data[3], 32'hDDDD_DDDD);
        check("bp_last3", cap_last[3], 1);
        check("bp_last2", cap_last[2], 0);
        check("bp_end_valid", sif.m_valid, 0);

        // Overflow: 10 records, sink stalled
        do_reset();
        for (int i = 0; i < 10; i++) begin
            trace_data = {1'b1, mk_rec(32'(i))};
            tick();
        end
        trace_data = '0;
        check("ovf_level", fifo_level, 8);
        check("ovf_drop", drop_count, 1);
        check("ovf_valid", sif.m_valid, 1);
        check("ovf_busy", busy, 1);
        sif.m_ready = 1'b1;
        collect(40, 80);
        check("ovf_beats", cap_n, 36);
        for (int k = 0; k < 36; k++) begin
            check("ovf_data", cap_data[k], 32'hA000_0000 | 32'((k / 4) << 8) | 32'(k % 4));
            check("ovf_last", cap_last[k], (k % 4 == 3));
        end
        check("ovf_end_busy", busy, 0);
        check("ovf_end_drop", drop_count, 1);

        // Flush after beat 1 of record 0 with two more queued
        do_reset();
        for (int i = 0; i < 3; i++) begin
            trace_data = {1'b1, mk_rec(32'(20 + i))};
            tick();
        end
        trace_data = '0;
        check("fl_level", fifo_level, 2);
        sif.m_ready = 1'b1;
        tick();
        tick();
        check("fl_pre_data", sif.m_data, 32'hA000_1402);
        sif.m_ready = 1'b0;
        flush = 1'b1;
        trace_data = {1'b1, mk_rec(99)};
        tick();
        flush = 1'b0;
        trace_data = '0;
        check("fl_valid", sif.m_valid, 0);
        check("fl_level0", fifo_level, 0);
        check("fl_busy", busy, 0);
        check("fl_drop", drop_count, 0);
        tick();
        check("fl_valid2", sif.m_valid, 0);
        sif.m_ready = 1'b1;
        send_rec(mk_rec(30));
        collect(4, 20);
        check("fl_beats", cap_n, 4);
        for (int k = 0; k < 4; k++) begin
            check("fl_new_data", cap_data[k], 32'hA000_1E00 | 32'(k));
            check("fl_new_last", cap_last[k], (k == 3));
        end
        check("fl_end_busy", busy, 0);

        // Capture gating
        do_reset();
        capture_en  = 1'b0;
        sif.m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            trace_data = {1'b1, mk_rec(32'(40 + i))};
            tick();
            check("gate_valid", sif.m_valid, 0);
        end
        trace_data = '0;
        tick();
        tick();
        check("gate_valid_end", sif.m_valid, 0);
        check("gate_level", fifo_level, 0);
        check("gate_drop", drop_count, 0);
        check("gate_busy", busy, 0);
        capture_en = 1'b1;

        // Reset during SEND, with a record strobe in the reset cycle
        do_reset();
        send_rec(mk_rec(50));
        send_rec(mk_rec(51));
        check("rs_valid", sif.m_valid, 1);
        check("rs_level", fifo_level, 1);
        sif.m_ready = 1'b1;
        tick();
        check("rs_mid_data", sif.m_data, 32'hA000_3201);
        rst = 1'b1;
        trace_data = {1'b1, mk_rec(52)};
        tick();
        rst = 1'b0;
        trace_data = '0;
        check("rs_valid0", sif.m_valid, 0);
        check("rs_last0", sif.m_last, 0);
        check("rs_data0", sif.m_data, 0);
        check("rs_level0", fifo_level, 0);
        check("rs_busy0", busy, 0);
        tick();
        check("rs_idle_valid", sif.m_valid, 0);

        // Drop counter saturation, then flush keeps the count
        do_reset();
        trace_data = {1'b1, mk_rec(7)};
        for (int c = 1; c <= 65549; c++) begin
            tick();
            if (c == 9) begin
                check("sat_fill_level", fifo_level, 8);
                check("sat_fill_drop", drop_count, 0);
            end
            if (c == 9 + 65534) check("sat_fffe", drop_count, 16'hFFFE);
            if (c == 9 + 65535) check("sat_ffff", drop_count, 16'hFFFF);
        end
        trace_data = '0;
        check("sat_hold", drop_count, 16'hFFFF);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("sat_flush_drop", drop_count, 16'hFFFF);
        check("sat_flush_level", fifo_level, 0);
        check("sat_flush_valid", sif.m_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trace_stream_ctrl.md
Name: trace_stream_ctrl

Overview:
- Sits between the trace core's 129-bit record output and a 32-bit streaming sink (debug UART bridge or DMA).
- Captures each valid trace record, buffers it in a small FIFO and serialises each record into 4 beats with a valid/ready handshake.
- Software can enable capture, flush the buffer and read an overflow-drop counter.
- Decouples the single-cycle record strobe from sink back-pressure, so no record is lost silently.

Parameters:
- DEPTH, 8, number of 128-bit records buffered; power of two, 2..64.
- BEAT_W, 32, output beat width; fixed at 32, and 128/BEAT_W = 4 beats per record.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- trace_data_i  in  129  bit 128 = record valid strobe, one cycle per record; bits 127:0 = record payload.
- capture_en  in  1  level; records are accepted only while high.
- flush  in  1  one-cycle pulse; discards all buffered records and any partially sent record.
- m_data  out  32  current beat.
- m_valid  out  1  beat valid.
- m_last  out  1  high on the 4th beat of a record.
- m_ready  in  1  sink ready.
- fifo_level  out  $clog2(DEPTH)+1  number of records buffered, excluding the record being sent.
- drop_count  out  DROP_W  saturating count of records rejected because the FIFO was full.
- busy  out  1  high when the FIFO is non-empty or the FSM is in SEND.

Behaviour:
Reset:
- One clock is used; reset is synchronous and active-high, named rst (clock named clk).
- rst is sampled on the clk rising edge and has priority over all other inputs.
- Reset values: m_valid=0, m_last=0, m_data=0, fifo_level=0, drop_count=0, busy=0. FSM goes to IDLE and the FIFO pointers are cleared.

Write side:
- On a cycle with trace_data_i[128]=1, capture_en=1 and flush=0, the payload is pushed if the FIFO is not full.
- If the FIFO is full, the record is dropped and drop_count increments, saturating at all-ones.
- A pop in the same cycle does not free space for the incoming push; full is evaluated before the pop.
- A valid record while capture_en=0 is ignored and not counted.

FSM:
- IDLE: when the FIFO is non-empty, pop the head record into the shift register and go to SEND. m_valid rises the cycle after the pop (1-cycle latency from non-empty to m_valid).
- SEND:
  - m_data = payload[32*beat+31 : 32*beat], where beat is a 2-bit counter starting at 0. Bits 31:0 go out first (little-endian beat order).
  - A beat completes on m_valid && m_ready; beat then increments.
  - m_last = (beat==3).
  - When the beat-3 handshake completes: if the FIFO is non-empty, pop the next record and stay in SEND with beat=0 (back-to-back, no bubble); otherwise go to IDLE with m_valid=0.
  - m_data/m_valid/m_last are registered outputs. While m_valid=1 and m_ready=0, m_data and m_last must hold stable.
- FLUSH: entered from any state when flush=1.
  - In that cycle: the FIFO is emptied, beat=0, m_valid=0 next cycle, and the FSM returns to IDLE the following cycle.
  - A record arriving in the flush cycle is discarded and not counted.
  - drop_count is not cleared by flush, only by rst.

Width and boundary rules:
- fifo_level ranges 0..DEPTH and is updated each cycle: +1 on push, -1 on pop, unchanged on push+pop.
- FIFO pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- The sink may hold m_ready=1 permanently; the sustained rate is then 1 record per 4 cycles.
- Records arriving faster than 1 per 4 cycles accumulate in the FIFO and overflow into drop_count.
- When capture_en falls mid-record, the record being sent and all buffered records still drain.
- rst asserted mid-record abandons the beat immediately; m_valid=0 on the next edge.

Decomposition:
- Package trace_stream_pkg holds:
  - constants TRACE_REC_W=129, TRACE_VALID_BIT=128, TRACE_PAYLOAD_W=128, BEATS_PER_REC=4;
  - enum state_t {IDLE, SEND, FLUSH}.
- One sub-module: trace_rec_fifo. It is a synchronous FIFO of DEPTH x 128 with push, pop, clear, full, empty and level ports, on the same clk/rst.
- Serialiser, FSM and drop counter live in the top module.

Test Plan:
- Single record: payload 0x44444444_33333333_22222222_11111111, m_ready=1 -> beats 0x11111111, 0x22222222, 0x33333333, 0x44444444; m_last on the 4th beat only; m_valid rises 1 cycle after the push is registered; busy=0 after the last beat.
- Back-pressure: m_ready toggled 1,0,0,1,... during a record -> m_data held stable through stalls; exactly 4 handshakes; no duplicated or skipped beat.
- Overflow, DEPTH=8, m_ready=0: 10 records on consecutive cycles -> after the first record is popped into the shift register, fifo_level=8 and drop_count=1 (9 stored including the record being sent). Releasing m_ready yields 36 beats.
- Saturation: force 65540 drops with DROP_W=16 -> drop_count=0xFFFF and stays there.
- Flush mid-record: 3 records queued, flush pulsed after beat 1 of record 0 -> m_valid=0 next cycle, fifo_level=0, busy=0; a new record then sends normally from beat 0.
- Reset and gating: capture_en=0 with 5 valid records -> no output and drop_count=0. rst during SEND -> all outputs at reset values next cycle.
